// File: rtl/wbm_initiator.sv
// Single-outstanding Wishbone B4 pipelined master: one command in, one bus cycle, one response pulse.
// Define WBM_TIMEOUT_EN to abort REQ/WAIT after TIMEOUT cycles with an error response.
module wbm_initiator #(
  parameter int AW      = 8,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_cmd_valid,
  output logic            o_cmd_ready,
  input  logic            i_cmd_we,
  input  logic [AW-1:0]   i_cmd_addr,
  input  logic [DW-1:0]   i_cmd_data,
  input  logic [DW/8-1:0] i_cmd_sel,
  output logic            o_rsp_valid,
  output logic [DW-1:0]   o_rsp_data,
  output logic            o_rsp_err,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic            o_wb_we,
  output logic [AW-1:0]   o_wb_addr,
  output logic [DW-1:0]   o_wb_data,
  output logic [DW/8-1:0] o_wb_sel,
  input  logic            i_wb_stall,
  input  logic            i_wb_ack,
  input  logic            i_wb_err,
  input  logic [DW-1:0]   i_wb_data
);

  // state  | meaning
  // S_IDLE | ready for a command
  // S_REQ  | strobe presented, waiting for stall to drop
  // S_WAIT | strobe accepted, waiting for ack/err
  // S_RESP | response pulse cycle
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  if (TIMEOUT < 2 || (DW % 8) != 0) begin : g_bad_param
    $error("wbm_initiator: TIMEOUT must be >= 2 and DW a multiple of 8");
  end

  state_t            state_q, state_d;
  logic              ready_q, ready_d;
  logic              cyc_q, cyc_d;
  logic              stb_q, stb_d;
  logic              we_q, we_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [DW/8-1:0]   sel_q, sel_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]     rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              accept;
  logic              bus_done;

  assign accept   = (state_q == S_IDLE) && ready_q && i_cmd_valid;
  assign bus_done = i_wb_ack || i_wb_err;

`ifdef WBM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          expire;

  // Fires on the edge at which the counter would reach TIMEOUT.
  assign expire = ((state_q == S_REQ) || (state_q == S_WAIT && !bus_done)) &&
                  (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (accept)
      cnt_d = '0;
    else if (state_q == S_REQ || state_q == S_WAIT)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end
`endif

  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    sel_d       = sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (accept) begin
          we_d    = i_cmd_we;
          addr_d  = i_cmd_addr;
          wdata_d = i_cmd_data;
          sel_d   = i_cmd_sel;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          ready_d = 1'b0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (!i_wb_stall) begin
          stb_d   = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus_done) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = i_wb_err;
          rsp_data_d  = (i_wb_ack && !i_wb_err && !we_q) ? i_wb_data : '0;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid_d = 1'b0;
        ready_d     = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef WBM_TIMEOUT_EN
    if (expire) begin
      cyc_d       = 1'b0;
      stb_d       = 1'b0;
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b1;
      rsp_data_d  = '0;
      state_d     = S_RESP;
    end
`endif
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign o_cmd_ready = ready_q;
  assign o_wb_cyc    = cyc_q;
  assign o_wb_stb    = stb_q;
  assign o_wb_we     = we_q;
  assign o_wb_addr   = addr_q;
  assign o_wb_data   = wdata_q;
  assign o_wb_sel    = sel_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_wbm_initiator.sv
// Directed bench for wbm_initiator: read, stalled write, error, back-to-back, async reset, timeout.
module tb_wbm_initiator;
  localparam int AW = 8;
  localparam int DW = 32;

  logic            i_clk;
  logic            i_reset_n;
  logic            i_cmd_valid;
  logic            o_cmd_ready;
  logic            i_cmd_we;
  logic [AW-1:0]   i_cmd_addr;
  logic [DW-1:0]   i_cmd_data;
  logic [DW/8-1:0] i_cmd_sel;
  logic            o_rsp_valid;
  logic [DW-1:0]   o_rsp_data;
  logic            o_rsp_err;
  logic            o_wb_cyc;
  logic            o_wb_stb;
  logic            o_wb_we;
  logic [AW-1:0]   o_wb_addr;
  logic [DW-1:0]   o_wb_data;
  logic [DW/8-1:0] o_wb_sel;
  logic            i_wb_stall;
  logic            i_wb_ack;
  logic            i_wb_err;
  logic [DW-1:0]   i_wb_data;

  int n_cmp = 0;
  int n_mis = 0;

  wbm_initiator #(.AW(AW), .DW(DW), .TIMEOUT(15)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_we(i_cmd_we),
    .i_cmd_addr(i_cmd_addr), .i_cmd_data(i_cmd_data), .i_cmd_sel(i_cmd_sel),
    .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
    .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err), .i_wb_data(i_wb_data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_cmd(input logic v, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW/8-1:0] s);
    i_cmd_valid = v;
    i_cmd_we    = we;
    i_cmd_addr  = a;
    i_cmd_data  = d;
    i_cmd_sel   = s;
  endtask

  task automatic set_slave(input logic stall, input logic ack, input logic err, input logic [DW-1:0] d);
    i_wb_stall = stall;
    i_wb_ack   = ack;
    i_wb_err   = err;
    i_wb_data  = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stb_cycles;
    logic seen_rsp;
    i_reset_n = 1'b0;
    set_cmd(1'b0, 1'b0, '0, '0, '0);
    set_slave(1'b0, 1'b0, 1'b0, '0);
    #1;
    check_val("rst_ready", o_cmd_ready, 0);
    check_val("rst_cyc_stb", {o_wb_cyc, o_wb_stb, o_wb_we}, 0);
    check_val("rst_rsp", {o_rsp_valid, o_rsp_err, o_rsp_data}, 0);
    check_val("rst_bus", {o_wb_addr, o_wb_data, o_wb_sel}, 0);
    tick(); tick();
    check_val("rst_hold_ready", o_cmd_ready, 0);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    #1;
    check_val("rel_ready_low", o_cmd_ready, 0);
    tick();
    check_val("rel_ready_high", o_cmd_ready, 1);

    // read 0x05, ack one cycle after strobe accept
    set_cmd(1'b1, 1'b0, 8'h05, 32'h0, 4'hF);
    tick();
    set_cmd(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    check_val("rd_e0_cyc_stb", {o_wb_cyc, o_wb_stb}, 2'b11);
    check_val("rd_e0_ready", o_cmd_ready, 0);
    check_val("rd_e0_addr_we", {o_wb_addr, o_wb_we}, {8'h05, 1'b0});
    tick();
    check_val("rd_e1_cyc_stb", {o_wb_cyc, o_wb_stb}, 2'b10);
    set_slave(1'b0, 1'b1, 1'b0, 32'hDEADBEEF);
    tick();
    set_slave(1'b0, 1'b0, 1'b0, 32'h0);
    check_val("rd_e2_rsp_valid", o_rsp_valid, 1);
    check_val("rd_e2_rsp_data", o_rsp_data, 32'hDEADBEEF);
    check_val("rd_e2_rsp_err", o_rsp_err, 0);
    check_val("rd_e2_cyc_ready", {o_wb_cyc, o_cmd_ready}, 2'b00);
    tick();
    check_val("rd_e3_rsp_valid", o_rsp_valid, 0);
    check_val("rd_e3_ready", o_cmd_ready, 1);
    check_val("rd_e3_data_hold", o_rsp_data, 32'hDEADBEEF);

    // write 0x10 with stall held for 3 cycles; an early ack during REQ must be ignored
    set_cmd(1'b1, 1'b1, 8'h10, 32'h12345678, 4'hF);
    set_slave(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    set_cmd(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    stb_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      if (o_wb_stb) stb_cycles++;
      check_val("wr_stall_bus", {o_wb_cyc, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel},
                {1'b1, 1'b1, 8'h10, 32'h12345678, 4'hF});
      set_slave(1'b1, (i == 0), 1'b0, 32'hA5A5A5A5);
      tick();
    end
    if (o_wb_stb) stb_cycles++;
    check_val("wr_stall_last_bus", {o_wb_cyc, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel},
              {1'b1, 1'b1, 8'h10, 32'h12345678, 4'hF});
    check_val("wr_early_ack_ignored", o_rsp_valid, 0);
    set_slave(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    if (o_wb_stb) stb_cycles++;
    check_val("wr_stb_cycles", stb_cycles, 4);
    check_val("wr_wait_cyc_stb", {o_wb_cyc, o_wb_stb}, 2'b10);
    set_slave(1'b0, 1'b1, 1'b0, 32'hA5A5A5A5);
    tick();
    set_slave(1'b0, 1'b0, 1'b0, 32'h0);
    check_val("wr_rsp", {o_rsp_valid, o_rsp_err, o_rsp_data}, {1'b1, 1'b0, 32'h0});
    check_val("wr_cyc_drop", o_wb_cyc, 0);
    tick();
    check_val("wr_ready", {o_cmd_ready, o_rsp_valid}, 2'b10);

    // read with ack and err together: err wins, data forced to 0
    set_cmd(1'b1, 1'b0, 8'h22, 32'h0, 4'h3);
    tick();
    set_cmd(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    tick();
    set_slave(1'b0, 1'b1, 1'b1, 32'hFFFF0000);
    tick();
    set_slave(1'b0, 1'b0, 1'b0, 32'h0);
    check_val("err_rsp", {o_rsp_valid, o_rsp_err, o_rsp_data}, {1'b1, 1'b1, 32'h0});
    check_val("err_cyc_drop", o_wb_cyc, 0);
    tick();
    check_val("err_hold", {o_cmd_ready, o_rsp_valid, o_rsp_err}, 3'b101);

    // back-to-back: valid held high, second accept exactly 4 edges after the first
    set_cmd(1'b1, 1'b0, 8'h30, 32'h0, 4'hF);
    tick();
    check_val("b2b_a_accept", {o_wb_cyc, o_wb_stb, o_wb_addr, o_cmd_ready}, {2'b11, 8'h30, 1'b0});
    set_cmd(1'b1, 1'b0, 8'h31, 32'h0, 4'hF);
    tick();
    check_val("b2b_e1_ready", {o_cmd_ready, o_wb_stb, o_wb_addr}, {1'b0, 1'b0, 8'h30});
    set_slave(1'b0, 1'b1, 1'b0, 32'h11111111);
    tick();
    set_slave(1'b0, 1'b0, 1'b0, 32'h0);
    check_val("b2b_e2", {o_cmd_ready, o_rsp_valid, o_rsp_data}, {2'b01, 32'h11111111});
    tick();
    check_val("b2b_e3", {o_cmd_ready, o_wb_cyc, o_rsp_valid}, 3'b100);
    tick();
    set_cmd(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    check_val("b2b_b_accept", {o_wb_cyc, o_wb_stb, o_wb_addr, o_cmd_ready}, {2'b11, 8'h31, 1'b0});
    tick();
    set_slave(1'b0, 1'b1, 1'b0, 32'h22222222);
    tick();
    set_slave(1'b0, 1'b0, 1'b0, 32'h0);
    check_val("b2b_b_rsp", {o_rsp_valid, o_rsp_data}, {1'b1, 32'h22222222});
    tick();
    check_val("b2b_b_done", o_cmd_ready, 1);

    // asynchronous reset while in WAIT
    set_cmd(1'b1, 1'b0, 8'h40, 32'h0, 4'hF);
    tick();
    set_cmd(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    tick();
    check_val("arst_in_wait", {o_wb_cyc, o_wb_stb}, 2'b10);
    #2;
    i_reset_n = 1'b0;
    #1;
    check_val("arst_async_clear", {o_wb_cyc, o_wb_stb, o_rsp_valid, o_cmd_ready}, 4'b0000);
    set_slave(1'b0, 1'b1, 1'b0, 32'h33333333);
    tick();
    check_val("arst_no_rsp", {o_rsp_valid, o_wb_cyc}, 2'b00);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    set_slave(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check_val("arst_ready_after", {o_cmd_ready, o_rsp_valid, o_wb_cyc}, 3'b100);

    // slave never answers
    set_cmd(1'b1, 1'b0, 8'h55, 32'h0, 4'hF);
    tick();
    set_cmd(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    seen_rsp = 1'b0;
`ifdef WBM_TIMEOUT_EN
    for (int k = 1; k < 15; k++) begin
      tick();
      if (o_rsp_valid) seen_rsp = 1'b1;
    end
    check_val("to_no_early_rsp", {seen_rsp, o_wb_cyc}, 2'b01);
    tick();
    check_val("to_rsp", {o_rsp_valid, o_rsp_err, o_rsp_data}, {1'b1, 1'b1, 32'h0});
    check_val("to_cyc_stb", {o_wb_cyc, o_wb_stb}, 2'b00);
    tick();
    check_val("to_ready", {o_cmd_ready, o_rsp_valid}, 2'b10);
`else
    for (int k = 1; k <= 120; k++) begin
      tick();
      if (o_rsp_valid) seen_rsp = 1'b1;
    end
    check_val("nto_cyc_held", {o_wb_cyc, o_cmd_ready}, 2'b10);
    check_val("nto_no_rsp", seen_rsp, 0);
    #2;
    i_reset_n = 1'b0;
    #1;
    check_val("nto_reset_abort", o_wb_cyc, 0);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
